// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: round-robin with
// bounded lock, combinational grant and RAM mux, registered read-valid tracking.
module ram_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_salida
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  owner_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             a_rvalid_q, b_rvalid_q;

  logic own_req, own_lock, oth_req;
  logic lock_expired, lock_hold, gnt_lock;

  // State register: owner of the last accepted access and locked-run length
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= OWN_B;
      lock_cnt_q   <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      a_rvalid_q   <= a_gnt & ~a_we;
      b_rvalid_q   <= b_gnt & ~b_we;
    end
  end

  // Grant decision and next-state
  always_comb begin
    a_gnt        = 1'b0;
    b_gnt        = 1'b0;
    last_grant_d = last_grant_q;
    lock_cnt_d   = '0;
    gnt_lock     = 1'b0;
    own_req      = (last_grant_q == OWN_B) ? b_req  : a_req;
    own_lock     = (last_grant_q == OWN_B) ? b_lock : a_lock;
    oth_req      = (last_grant_q == OWN_B) ? a_req  : b_req;
    lock_expired = (lock_cnt_q >= CNT_W'(MAX_LOCK)) && oth_req;
    lock_hold    = own_req && own_lock && (lock_cnt_q != '0) && !lock_expired;

    if (!reset) begin
      if (lock_hold) begin
        a_gnt = (last_grant_q == OWN_A);
        b_gnt = (last_grant_q == OWN_B);
      end else if (a_req && b_req) begin
        a_gnt = (last_grant_q == OWN_B);
        b_gnt = (last_grant_q == OWN_A);
      end else if (a_req) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end

    // A locked grant extends the run only if ownership did not change
    if (a_gnt || b_gnt) begin
      last_grant_d = b_gnt ? OWN_B : OWN_A;
      gnt_lock     = b_gnt ? b_lock : a_lock;
      if (gnt_lock) begin
        if (last_grant_d != last_grant_q) begin
          lock_cnt_d = CNT_W'(1);
        end else if (lock_cnt_q >= CNT_W'(MAX_LOCK)) begin
          lock_cnt_d = CNT_W'(MAX_LOCK);
        end else begin
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // RAM port mux
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (a_gnt) begin
      ram_address = a_addr;
      ram_data    = a_wdata;
      ram_wren    = a_we & a_req;
    end else if (b_gnt) begin
      ram_address = b_addr;
      ram_data    = b_wdata;
      ram_wren    = b_we & b_req;
    end
  end

  // A read pending across reset assertion is suppressed immediately
  assign a_rvalid = a_rvalid_q & ~reset;
  assign b_rvalid = b_rvalid_q & ~reset;
  assign a_rdata  = a_rvalid ? ram_salida : '0;
  assign b_rdata  = b_rvalid ? ram_salida : '0;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, RAM word-address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 Parameter MAX_LOCK, default 8, maximum consecutive locked grants to one requester.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a_req / b_req  input  1  requester A (CPU load/store) / B (debug loader) wants one RAM access this cycle.
REQ-007 a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 a_addr / b_addr  input  ADDR_W  word address.
REQ-009 a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 a_lock / b_lock  input  1  request to keep the grant on the next cycle.
REQ-011 a_gnt / b_gnt  output  1  combinational grant; access accepted at the rising edge where req and gnt are both 1.
REQ-012 a_rvalid / b_rvalid  output  1  registered; read data valid for that requester.
REQ-013 a_rdata / b_rdata  output  DATA_W  read data; equals ram_salida when the matching rvalid is 1, else 0.
REQ-014 ram_address  output  ADDR_W  to RAM address port.
REQ-015 ram_data  output  DATA_W  to RAM data port.
REQ-016 ram_wren  output  1  to RAM write enable.
REQ-017 ram_salida  input  DATA_W  RAM read data, valid one cycle after the address is sampled.

Function
REQ-018 At most one of a_gnt, b_gnt shall be 1 in any cycle; a grant shall never be given without the matching req.
REQ-019 Only one requester active: that requester shall be granted in the same cycle.
REQ-020 Both requesting, no active lock: grant goes to the requester not granted last (round-robin); last_grant updates on every accepted access.
REQ-021 Lock: while the current owner holds req=1 and lock=1, it keeps the grant; lock_cnt counts consecutive locked grants.
REQ-022 When lock_cnt reaches MAX_LOCK and the other requester is requesting, the grant shall pass to the other requester for at least one cycle; lock_cnt then clears.
REQ-023 lock_cnt clears whenever the owner drops req or lock, or ownership changes.
REQ-024 RAM mux (combinational): ram_address, ram_data, ram_wren follow the granted requester's addr, wdata, we&req; with no grant: ram_wren=0, ram_address=0, ram_data=0.
REQ-025 An accepted write is performed at the accepting edge; no rvalid is produced for writes.
REQ-026 An accepted read asserts the requester's rvalid for exactly one cycle, starting the cycle after acceptance (latency 1); back-to-back reads by one requester give rvalid on consecutive cycles.
REQ-027 A read accepted in the cycle after a write to the same address shall return the newly written data.
REQ-028 Address wrap: ADDR_W-bit addresses pass unmodified; 0 and 2^ADDR_W-1 are legal.
REQ-029 Requester changing addr, we, or wdata while not granted has no effect on the RAM.

Reset
REQ-030 While reset=1: a_gnt=b_gnt=0, ram_wren=0, ram_address=0, ram_data=0, a_rvalid=b_rvalid=0, rdata=0.
REQ-031 After reset: last_grant=B (A wins first conflict), lock_cnt=0.
REQ-032 Reset mid-read: the pending rvalid shall be discarded and stay 0 on the cycle after reset is applied.

Verification
REQ-033 A writes 43 to address 1, then A reads address 1 -> a_gnt=1 on both, a_rvalid=1 one cycle after the read with a_rdata=43, b_rvalid stays 0.
REQ-034 B writes 61 to address 32, then A reads address 32 on the next cycle -> a_rdata=61, b_gnt=0 during A's read.
REQ-035 A and B request reads simultaneously after reset, no lock, for 4 cycles -> grants A,B,A,B; each rvalid one cycle after its grant.
REQ-036 A holds req=1, lock=1 for 12 cycles while B requests continuously -> A granted 8 cycles, B granted cycle 9, then A resumes.
REQ-037 A issues a read of address 1023; reset is asserted on the next cycle -> a_rvalid=0 and all outputs at reset values.
REQ-038 No requests for 5 cycles -> ram_wren=0 and RAM contents at addresses 1 and 32 unchanged on subsequent reads.
